sync_data_memory: RTL and testbench

SYNC_DATA_MEMORY -- requirements
Module: sync_data_memory

---
 rtl/sync_data_memory.sv | 116 +++++++++++
 tb/tb_sync_data_memory.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_data_memory.sv
// Single-port word memory with a self-clearing FSM; reads return registered data one cycle later.
// Requests are taken only while ready is high (IDLE); everything presented during CLEAR is dropped.
module sync_data_memory #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  input  logic              dataMemRead,
  input  logic              dataMemWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] value,
  output logic              ready,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              addr_err
);

  localparam logic [0:0]        S_CLEAR   = 1'b0;
  localparam logic [0:0]        S_IDLE    = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_out;
  logic              r_out_vld;
  logic              r_addr_err;

  logic              w_idle;
  logic              w_in_range;
  logic              w_take;
  logic              w_wr;
  logic              w_rd;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_din;
  logic [DATA_W-1:0] w_rd_dat;

  assign w_idle     = (r_state == S_IDLE);
  assign w_in_range = ({1'b0, address} < DEPTH_EXT);
  // A clear request wins over any access presented in the same cycle; write wins over read.
  assign w_take     = w_idle && !clear_req;
  assign w_wr       = w_take && dataMemWrite;
  assign w_rd       = w_take && dataMemRead && !dataMemWrite;

  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = '0;
    w_mem_din  = '0;
    if (!w_idle) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_cnt;
    end else if (w_wr && w_in_range) begin
      w_mem_we   = 1'b1;
      w_mem_addr = address;
      w_mem_din  = value;
    end
  end

  // Array kept out of the reset domain so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_din;
    end
  end

  assign w_rd_dat = w_in_range ? r_mem[address] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_cnt == LAST_WORD) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (clear_req) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out      <= '0;
      r_out_vld  <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_out_vld  <= w_rd;
      r_addr_err <= (w_rd || w_wr) && !w_in_range;
      if (w_rd) begin
        r_out <= w_rd_dat;
      end
    end
  end

  assign ready     = w_idle;
  assign out       = r_out;
  assign out_valid = r_out_vld;
  assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_sync_data_memory.sv
// Bench for sync_data_memory: table vectors, corner sequences and random traffic vs. a behavioural model.
module tb_sync_data_memory;

  localparam int DW  = 16;
  localparam int AW  = 5;
  localparam int D   = 16;
  localparam int BAW = 4;
  localparam int BD  = 10;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst_n, a_clr, a_rd, a_wr;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_val;
  logic          a_ready, a_vld, a_err;
  logic [DW-1:0] a_out;

  logic           b_rst_n, b_clr, b_rd, b_wr;
  logic [BAW-1:0] b_addr;
  logic [DW-1:0]  b_val;
  logic           b_ready, b_vld, b_err;
  logic [DW-1:0]  b_out;

  sync_data_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .clear_req(a_clr), .dataMemRead(a_rd),
    .dataMemWrite(a_wr), .address(a_addr), .value(a_val), .ready(a_ready),
    .out(a_out), .out_valid(a_vld), .addr_err(a_err)
  );

  sync_data_memory #(.DATA_W(DW), .ADDR_W(BAW), .DEPTH(BD)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .clear_req(b_clr), .dataMemRead(b_rd),
    .dataMemWrite(b_wr), .address(b_addr), .value(b_val), .ready(b_ready),
    .out(b_out), .out_valid(b_vld), .addr_err(b_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: memory image plus number of clear cycles still owed.
  logic [DW-1:0] m_mem [D];
  int            m_clear_left;
  logic [DW-1:0] m_out;
  bit            m_vld, m_err;

  typedef struct {
    bit          rd;
    bit          wr;
    int          addr;
    logic [15:0] val;
    logic [15:0] eo;
    bit          ev;
    bit          ee;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step(input bit clr, input bit rd, input bit wr, input int addr,
                            input logic [DW-1:0] val);
    m_vld = 1'b0;
    m_err = 1'b0;
    if (m_clear_left > 0) begin
      m_mem[D - m_clear_left] = '0;
      m_clear_left--;
    end else if (clr) begin
      m_clear_left = D;
    end else if (wr) begin
      if (addr < D) m_mem[addr] = val;
      else m_err = 1'b1;
    end else if (rd) begin
      m_vld = 1'b1;
      if (addr < D) m_out = m_mem[addr];
      else begin
        m_out = '0;
        m_err = 1'b1;
      end
    end
  endtask

  task automatic step_a(input bit clr, input bit rd, input bit wr, input int addr,
                        input logic [DW-1:0] val, input string tag);
    a_clr  = clr;
    a_rd   = rd;
    a_wr   = wr;
    a_addr = AW'(addr);
    a_val  = val;
    @(posedge clk);
    #1;
    model_step(clr, rd, wr, addr, val);
    chk({tag, ".ready"}, {31'd0, a_ready}, {31'd0, m_clear_left == 0});
    chk({tag, ".out_valid"}, {31'd0, a_vld}, {31'd0, m_vld});
    chk({tag, ".addr_err"}, {31'd0, a_err}, {31'd0, m_err});
    chk({tag, ".out"}, {16'd0, a_out}, {16'd0, m_out});
    a_clr = 1'b0;
    a_rd  = 1'b0;
    a_wr  = 1'b0;
  endtask

  task automatic reset_a(input string tag);
    a_rst_n = 1'b0;
    #1;
    chk({tag, ".out"}, {16'd0, a_out}, 32'd0);
    chk({tag, ".out_valid"}, {31'd0, a_vld}, 32'd0);
    chk({tag, ".addr_err"}, {31'd0, a_err}, 32'd0);
    chk({tag, ".ready"}, {31'd0, a_ready}, 32'd0);
    m_clear_left = D;
    m_out        = '0;
    #1;
    a_rst_n = 1'b1;
  endtask

  task automatic step_b(input bit rd, input bit wr, input int addr, input logic [DW-1:0] val);
    b_rd   = rd;
    b_wr   = wr;
    b_addr = BAW'(addr);
    b_val  = val;
    @(posedge clk);
    #1;
    b_rd = 1'b0;
    b_wr = 1'b0;
  endtask

  initial begin
    vecs[0] = '{0, 1, 5,  16'hBEEF, 16'h0000, 0, 0};
    vecs[1] = '{1, 0, 5,  16'h0000, 16'hBEEF, 1, 0};
    vecs[2] = '{1, 1, 3,  16'h1234, 16'hBEEF, 0, 0};
    vecs[3] = '{1, 0, 3,  16'h0000, 16'h1234, 1, 0};
    vecs[4] = '{0, 0, 0,  16'h0000, 16'h1234, 0, 0};
    vecs[5] = '{0, 1, 20, 16'hFFFF, 16'h1234, 0, 1};
    vecs[6] = '{1, 0, 20, 16'h0000, 16'h0000, 1, 1};
    vecs[7] = '{1, 0, 5,  16'h0000, 16'hBEEF, 1, 0};
    vecs[8] = '{0, 1, 31, 16'h0001, 16'hBEEF, 0, 1};
    vecs[9] = '{1, 0, 0,  16'h0000, 16'h0000, 1, 0};

    a_rst_n = 1'b0; a_clr = 1'b0; a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_val = '0;
    b_rst_n = 1'b0; b_clr = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_val = '0;
    m_out = '0; m_vld = 1'b0; m_err = 1'b0; m_clear_left = D;
    #1;
    chk("reset.out", {16'd0, a_out}, 32'd0);
    chk("reset.ready", {31'd0, a_ready}, 32'd0);
    chk("reset.out_valid", {31'd0, a_vld}, 32'd0);
    chk("reset.addr_err", {31'd0, a_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    // Initial clear: ready must rise on exactly the 16th edge.
    for (int i = 0; i < D; i++) begin
      step_a(0, 0, 0, 0, '0, "init_clear");
      if (i == D - 2) chk("init_clear.ready_at_15", {31'd0, a_ready}, 32'd0);
    end
    chk("init_clear.ready_at_16", {31'd0, a_ready}, 32'd1);
    for (int i = 0; i < D; i++) begin
      step_a(0, 1, 0, i, '0, "read_cleared");
      chk("read_cleared.zero", {16'd0, a_out}, 32'd0);
    end

    for (int i = 0; i < 10; i++) begin
      step_a(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].val, "vec");
      chk("vec.tbl_out", {16'd0, a_out}, {16'd0, vecs[i].eo});
      chk("vec.tbl_vld", {31'd0, a_vld}, {31'd0, vecs[i].ev});
      chk("vec.tbl_err", {31'd0, a_err}, {31'd0, vecs[i].ee});
    end

    // Fill, clear, and hammer writes/clear_req during the clear.
    for (int i = 0; i < D; i++) step_a(0, 0, 1, i, DW'($urandom), "fill");
    step_a(1, 0, 0, 0, '0, "clear_req");
    for (int i = 0; i < D; i++) begin
      step_a(($urandom_range(0, 3) == 0), 1'($urandom), 1'b1, $urandom_range(0, D - 1),
             DW'($urandom), "clear_busy");
      if (i < D - 1) chk("clear_busy.ready_low", {31'd0, a_ready}, 32'd0);
    end
    chk("clear_busy.ready_high", {31'd0, a_ready}, 32'd1);
    for (int i = 0; i < D; i++) begin
      step_a(0, 1, 0, i, '0, "post_clear");
      chk("post_clear.zero", {16'd0, a_out}, 32'd0);
    end

    // Reset during operation and mid-clear.
    step_a(0, 0, 1, 5, 16'hBEEF, "pre_rst_wr");
    step_a(0, 1, 0, 5, '0, "pre_rst_rd");
    reset_a("rst_op");
    for (int i = 0; i < 7; i++) step_a(0, 0, 0, 0, '0, "clear7");
    reset_a("rst_mid");
    for (int i = 0; i < D; i++) begin
      step_a(0, 0, 0, 0, '0, "reclear");
      if (i == D - 2) chk("reclear.ready_at_15", {31'd0, a_ready}, 32'd0);
    end
    chk("reclear.ready_at_16", {31'd0, a_ready}, 32'd1);

    for (int i = 0; i < 400; i++) begin
      step_a(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom),
             $urandom_range(0, 31), DW'($urandom), "rand");
    end

    // Non-power-of-two depth instance.
    chk("b.ready", {31'd0, b_ready}, 32'd1);
    for (int i = 0; i < BD; i++) begin
      step_b(0, 1, i, DW'(16'hA000 + i));
      chk("b.fill_err", {31'd0, b_err}, 32'd0);
    end
    step_b(0, 1, 12, 16'hFFFF);
    chk("b.oor_wr_err", {31'd0, b_err}, 32'd1);
    chk("b.oor_wr_vld", {31'd0, b_vld}, 32'd0);
    step_b(0, 0, 0, '0);
    chk("b.err_one_cycle", {31'd0, b_err}, 32'd0);
    step_b(1, 0, 12, '0);
    chk("b.oor_rd_out", {16'd0, b_out}, 32'd0);
    chk("b.oor_rd_vld", {31'd0, b_vld}, 32'd1);
    chk("b.oor_rd_err", {31'd0, b_err}, 32'd1);
    for (int i = 0; i < BD; i++) begin
      step_b(1, 0, i, '0);
      chk("b.readback", {16'd0, b_out}, 32'hA000 + 32'(i));
      chk("b.readback_err", {31'd0, b_err}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
